keccak_round_controller: RTL

//  Sequences the Keccak-f[1600] permutation datapath: accepts a start handshake, drives round_num
//  (consumed by round_constant_generator) and round-enable strobes for NUM_ROUNDS cycles, then

---
 rtl/keccak_round_controller_if.sv | 63 ++++++
 rtl/keccak_round_controller.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/keccak_round_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : keccak_round_controller_if
// Description : Handshake and sequencing bundle between the Keccak round
//               controller, the sponge FSM upstream and the permutation
//               datapath downstream.
//                 flush       abort request back to IDLE
//                 in_valid    upstream requests a permutation
//                 in_ready    controller can accept a request
//                 state_load  datapath captures its input state
//                 round_en    datapath applies round round_num
//                 round_num   current round index
//                 round_num_b second round index (KECCAK_UNROLL2_EN only)
//                 last_round  final round strobe
//                 out_valid   permuted state available
//                 out_ready   downstream accepts permuted state
//                 busy        controller not idle
//               Modport master is the controller; modport slave is its
//               environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface keccak_round_controller_if #(
    parameter int RN_W = 5
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic            state_load;
    logic            round_en;
    logic [RN_W-1:0] round_num;
`ifdef KECCAK_UNROLL2_EN
    logic [RN_W-1:0] round_num_b;
`endif
    logic            last_round;
    logic            out_valid;
    logic            out_ready;
    logic            busy;

`ifdef KECCAK_UNROLL2_EN
    modport master (
        input  flush, in_valid, out_ready,
        output in_ready, state_load, round_en, round_num, round_num_b,
               last_round, out_valid, busy
    );
    modport slave (
        output flush, in_valid, out_ready,
        input  in_ready, state_load, round_en, round_num, round_num_b,
               last_round, out_valid, busy
    );
`else
    modport master (
        input  flush, in_valid, out_ready,
        output in_ready, state_load, round_en, round_num,
               last_round, out_valid, busy
    );
    modport slave (
        output flush, in_valid, out_ready,
        input  in_ready, state_load, round_en, round_num,
               last_round, out_valid, busy
    );
`endif
endinterface
`default_nettype wire

// File: rtl/keccak_round_controller.sv
`default_nettype none
// ============================================================================
// Module      : keccak_round_controller
// Description : Sequences the Keccak-f[1600] / Keccak-p permutation datapath.
//               Accepts a start handshake, issues NUM_ROUNDS round strobes
//               (rounds 24-NUM_ROUNDS .. 23) with the matching round index,
//               then holds a done handshake until it is accepted.
//               Ports:
//                 clk    rising-edge clock
//                 rst_n  asynchronous active-low reset
//                 bus    keccak_round_controller_if.master (handshakes,
//                        round index and strobes)
//               Build option KECCAK_UNROLL2_EN: two rounds per cycle,
//               round_num_b = round_num + 1, NUM_ROUNDS must be even.
// Revision    : 1.0 - initial release
// ============================================================================
module keccak_round_controller #(
    parameter int NUM_ROUNDS = 24,
    parameter int RN_W       = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    keccak_round_controller_if.master  bus
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_round = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

`ifdef KECCAK_UNROLL2_EN
    localparam logic [RN_W-1:0] c_step = RN_W'(2);
    localparam logic [RN_W-1:0] c_last = RN_W'(22);
`else
    localparam logic [RN_W-1:0] c_step = RN_W'(1);
    localparam logic [RN_W-1:0] c_last = RN_W'(23);
`endif
    // First round index for reduced-round Keccak-p variants
    localparam logic [RN_W-1:0] c_rfirst = RN_W'(24 - NUM_ROUNDS);

    generate
        if (NUM_ROUNDS < 1 || NUM_ROUNDS > 24) begin : g_bad_num_rounds
            $error("keccak_round_controller: NUM_ROUNDS must be 1..24");
        end
        if (RN_W != 5) begin : g_bad_rn_w
            $error("keccak_round_controller: RN_W must be 5");
        end
`ifdef KECCAK_UNROLL2_EN
        if ((NUM_ROUNDS % 2) != 0) begin : g_odd_num_rounds
            $error("keccak_round_controller: NUM_ROUNDS must be even when unrolled by 2");
        end
`endif
    endgenerate

    logic [1:0]      r_state;
    logic [RN_W-1:0] r_count;
    logic [1:0]      w_state_nxt;
    logic [RN_W-1:0] w_count_nxt;

    logic            w_in_ready;
    logic            w_state_load;
    logic            w_round_en;
    logic [RN_W-1:0] w_round_num;
    logic [RN_W-1:0] w_round_num_b;
    logic            w_last_round;
    logic            w_out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_in_ready    = 1'b0;
        w_state_load  = 1'b0;
        w_round_en    = 1'b0;
        w_round_num   = '0;
        w_round_num_b = '0;
        w_last_round  = 1'b0;
        w_out_valid   = 1'b0;

        case (r_state)
            c_st_idle: begin
                w_in_ready  = 1'b1;
                w_count_nxt = '0;
                if (bus.in_valid) begin
                    w_state_load = 1'b1;
                    w_state_nxt  = c_st_round;
                    w_count_nxt  = c_rfirst;
                end
            end
            c_st_round: begin
                w_round_en    = 1'b1;
                w_round_num   = r_count;
                w_round_num_b = r_count + RN_W'(1);
                // >= rather than == so a corrupted counter can never run past
                // the final round
                if (r_count >= c_last) begin
                    w_last_round = 1'b1;
                    w_state_nxt  = c_st_done;
                    w_count_nxt  = '0;
                end else begin
                    w_count_nxt = r_count + c_step;
                end
            end
            c_st_done: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_count_nxt = '0;
            end
        endcase

        // Flush overrides every transition and suppresses all strobes
        if (bus.flush) begin
            w_state_nxt  = c_st_idle;
            w_count_nxt  = '0;
            w_state_load = 1'b0;
            w_round_en   = 1'b0;
            w_last_round = 1'b0;
            w_out_valid  = 1'b0;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.state_load = w_state_load;
    assign bus.round_en   = w_round_en;
    assign bus.round_num  = w_round_num;
    assign bus.last_round = w_last_round;
    assign bus.out_valid  = w_out_valid;
    assign bus.busy       = (r_state != c_st_idle);

`ifdef KECCAK_UNROLL2_EN
    assign bus.round_num_b = w_round_num_b;
`else
    logic w_unused_b;
    assign w_unused_b = ^w_round_num_b;
`endif

endmodule
`default_nettype wire
